wb_forward_buffer: RTL

//  Write-back queue between EXEC/EXEC_FLOATING results and the register file.

---
 rtl/wb_forward_buffer_pkg.sv | 11 +
 rtl/wb_forward_buffer_if.sv | 32 +++
 rtl/wbfb_lookup.sv | 42 ++++
 rtl/wb_forward_buffer.sv | 84 ++++++++
 4 files changed

// File: rtl/wb_forward_buffer_pkg.sv
// Shared defaults and helpers for the write-back forwarding buffer.
package wb_forward_buffer_pkg;
    localparam int D_SIZE_DEF = 32;
    localparam int REG_AW_DEF = 3;
    localparam int DEPTH_DEF  = 4;

    // Pointer width for a power-of-two queue, never below 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/wb_forward_buffer_if.sv
// Bus bundle between exec producer, regfile write port, READ stage and the buffer.
interface wb_forward_buffer_if
    import wb_forward_buffer_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF,
    parameter int REG_AW = REG_AW_DEF
);
    logic              wb_valid;
    logic [REG_AW-1:0] wb_dest;
    logic [D_SIZE-1:0] wb_data;
    logic              wb_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_addr;
    logic [D_SIZE-1:0] rf_data;
    logic              rf_ready;
    logic [REG_AW-1:0] rd_addr1;
    logic [REG_AW-1:0] rd_addr2;
    logic              fwd_hit1;
    logic [D_SIZE-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [D_SIZE-1:0] fwd_data2;

    modport slave (
        input  wb_valid, wb_dest, wb_data, rf_ready, rd_addr1, rd_addr2,
        output wb_ready, rf_we, rf_addr, rf_data, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2
    );

    modport master (
        output wb_valid, wb_dest, wb_data, rf_ready, rd_addr1, rd_addr2,
        input  wb_ready, rf_we, rf_addr, rf_data, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2
    );
endinterface

// File: rtl/wbfb_lookup.sv
// Associative priority search: incoming result first, then queue entries newest to oldest.
module wbfb_lookup
    import wb_forward_buffer_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF
)(
    input  logic [DEPTH-1:0][REG_AW-1:0] ent_dest,
    input  logic [DEPTH-1:0][D_SIZE-1:0] ent_data,
    input  logic [DEPTH-1:0]             ent_vld,
    input  logic [ptr_w(DEPTH)-1:0]      tail,
    input  logic                         in_vld,
    input  logic [REG_AW-1:0]            in_dest,
    input  logic [D_SIZE-1:0]            in_data,
    input  logic [REG_AW-1:0]            query,
    output logic                         hit,
    output logic [D_SIZE-1:0]            data
);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest (tail-DEPTH) to newest (tail-1) so later matches overwrite
    // earlier ones; invalid slots are skipped, so a partly filled queue works.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail - PW'(i);
            if (ent_vld[idx] && ent_dest[idx] == query) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
        if (in_vld && in_dest == query) begin
            hit  = 1'b1;
            data = in_data;
        end
    end
endmodule

// File: rtl/wb_forward_buffer.sv
// Write-back FIFO to the regfile with two forwarding lookup ports for the READ stage.
module wb_forward_buffer
    import wb_forward_buffer_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF
)(
    input  logic                clk,
    input  logic                rst,
    wb_forward_buffer_if.slave  bus
);
    localparam int PW = ptr_w(DEPTH);

    logic [DEPTH-1:0][REG_AW-1:0] ent_dest;
    logic [DEPTH-1:0][D_SIZE-1:0] ent_data;
    logic [DEPTH-1:0]             ent_vld;
    logic [PW-1:0]                head, tail;
    logic [PW:0]                  count;
    logic                         rf_we, wb_ready, push, pop;

    assign rf_we    = (count != '0);
    assign pop      = rf_we & bus.rf_ready;
    // A full queue still takes a result when the head drains in the same cycle.
    assign wb_ready = (count < (PW+1)'(DEPTH)) | pop;
    assign push     = bus.wb_valid & wb_ready;

    assign bus.rf_we    = rf_we;
    assign bus.wb_ready = wb_ready;
    assign bus.rf_addr  = ent_dest[head];
    assign bus.rf_data  = ent_data[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            // Placed after the pop so a full push+pop on the same slot leaves it valid.
            if (push) begin
                ent_vld[tail]  <= 1'b1;
                ent_dest[tail] <= bus.wb_dest;
                ent_data[tail] <= bus.wb_data;
                tail           <= tail + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    logic [1:0][REG_AW-1:0] query;
    logic [1:0]             hit;
    logic [1:0][D_SIZE-1:0] fdata;

    assign query = {bus.rd_addr2, bus.rd_addr1};

    for (genvar p = 0; p < 2; p++) begin : g_port
        wbfb_lookup #(.D_SIZE(D_SIZE), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_lookup (
            .ent_dest (ent_dest),
            .ent_data (ent_data),
            .ent_vld  (ent_vld),
            .tail     (tail),
            .in_vld   (push),
            .in_dest  (bus.wb_dest),
            .in_data  (bus.wb_data),
            .query    (query[p]),
            .hit      (hit[p]),
            .data     (fdata[p])
        );
    end

    assign bus.fwd_hit1  = hit[0];
    assign bus.fwd_data1 = fdata[0];
    assign bus.fwd_hit2  = hit[1];
    assign bus.fwd_data2 = fdata[1];
endmodule
